// File: rtl/spa_argmax_pkg.sv
// Shared constants and helpers for the serial/parallel signed argmax block.
// Used by argmax_node and serial_parallel_argmax_signed16.
package spa_argmax_pkg;

    localparam int NUM_INPUTS = 16;
    localparam int LANE_W     = 4;

    // Lane number inside one 16-wide vector; each node forwards one {value, lane} pair.
    typedef logic [LANE_W-1:0] lane_t;

    // Operands are sign-extended to 64 bits by the caller, so this serves any WIDTH <= 64.
    // Ties go to a, which always carries the lower lane.
    function automatic logic a_wins(input logic signed [63:0] a, input logic signed [63:0] b);
        return a >= b;
    endfunction

endpackage

// File: rtl/argmax_node.sv
// Two-input signed compare/select of a {value, lane} pair.
// On a tie input a (the lower lane) is selected.
module argmax_node
    import spa_argmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a_val,
    input  lane_t                   a_lane,
    input  logic signed [WIDTH-1:0] b_val,
    input  lane_t                   b_lane,
    output logic signed [WIDTH-1:0] y_val,
    output lane_t                   y_lane
);

    always_comb begin
        if (a_wins(64'(a_val), 64'(b_val))) begin
            y_val  = a_val;
            y_lane = a_lane;
        end else begin
            y_val  = b_val;
            y_lane = b_lane;
        end
    end

endmodule

// File: rtl/serial_parallel_argmax_signed16.sv
// Running signed argmax over a stream of 16-wide vectors (8-4-2-1 compare tree + running max).
// Optional `valid` output is enabled by defining SPA_VALID_OUT_EN.
module serial_parallel_argmax_signed16
    import spa_argmax_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] in [NUM_INPUTS],
    output logic signed [WIDTH-1:0] max,
`ifdef SPA_VALID_OUT_EN
    output logic                    valid,
`endif
    output logic [ARGMAX_WIDTH-1:0] argmax
);

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] l1_val [8];
    lane_t                   l1_lane [8];
    logic signed [WIDTH-1:0] l2_val [4];
    lane_t                   l2_lane [4];
    logic signed [WIDTH-1:0] l3_val [2];
    lane_t                   l3_lane [2];
    logic signed [WIDTH-1:0] tree_max;
    lane_t                   tree_lane;

    // Left children always hold the lower lanes, so the node tie rule yields lowest-lane-wins.
    for (genvar i = 0; i < 8; i++) begin : g_l1
        argmax_node #(.WIDTH(WIDTH)) u_node (
            .a_val (in[2*i]),
            .a_lane(lane_t'(2*i)),
            .b_val (in[2*i+1]),
            .b_lane(lane_t'(2*i+1)),
            .y_val (l1_val[i]),
            .y_lane(l1_lane[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_l2
        argmax_node #(.WIDTH(WIDTH)) u_node (
            .a_val (l1_val[2*i]),
            .a_lane(l1_lane[2*i]),
            .b_val (l1_val[2*i+1]),
            .b_lane(l1_lane[2*i+1]),
            .y_val (l2_val[i]),
            .y_lane(l2_lane[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_l3
        argmax_node #(.WIDTH(WIDTH)) u_node (
            .a_val (l2_val[2*i]),
            .a_lane(l2_lane[2*i]),
            .b_val (l2_val[2*i+1]),
            .b_lane(l2_lane[2*i+1]),
            .y_val (l3_val[i]),
            .y_lane(l3_lane[i])
        );
    end

    argmax_node #(.WIDTH(WIDTH)) u_root (
        .a_val (l3_val[0]),
        .a_lane(l3_lane[0]),
        .b_val (l3_val[1]),
        .b_lane(l3_lane[1]),
        .y_val (tree_max),
        .y_lane(tree_lane)
    );

    logic signed [WIDTH-1:0] max_q, max_d;
    logic [ARGMAX_WIDTH-1:0] argmax_q, argmax_d;
    logic [ARGMAX_WIDTH-1:0] base_q, base_d;

    // base_q's low four bits are always zero, so adding the lane equals concatenating it.
    always_comb begin
        max_d    = max_q;
        argmax_d = argmax_q;
        base_d   = base_q;
        if (enable) begin
            base_d = base_q + ARGMAX_WIDTH'(NUM_INPUTS);
            if (tree_max > max_q) begin
                max_d    = tree_max;
                argmax_d = base_q + ARGMAX_WIDTH'(tree_lane);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q    <= MOST_NEG;
            argmax_q <= '0;
            base_q   <= '0;
        end else begin
            max_q    <= max_d;
            argmax_q <= argmax_d;
            base_q   <= base_d;
        end
    end

    assign max    = max_q;
    assign argmax = argmax_q;

`ifdef SPA_VALID_OUT_EN
    logic valid_q, valid_d;

    always_comb begin
        valid_d = valid_q | enable;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    assign valid = valid_q;
`endif

endmodule

// File: tb/tb_serial_parallel_argmax_signed16.sv
// Self-checking bench: directed vectors with literal expectations plus random traffic,
// all compared every cycle against a behavioural running-argmax model.
module tb_serial_parallel_argmax_signed16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic signed [7:0] in_v [16];
    logic signed [7:0] max_o;
    logic [7:0]        argmax_o;
`ifdef SPA_VALID_OUT_EN
    logic              valid_o;
`endif

    serial_parallel_argmax_signed16 #(.WIDTH(8), .ARGMAX_WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .in    (in_v),
        .max   (max_o),
`ifdef SPA_VALID_OUT_EN
        .valid (valid_o),
`endif
        .argmax(argmax_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_max   = -128;
    int m_arg   = 0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;
    bit m_known = 1'b0;

    logic signed [7:0] stim [16];

    task automatic model_update(input bit r, input bit en);
        int best;
        if (r) begin
            m_max = -128; m_arg = 0; m_cnt = 0; m_valid = 1'b0; m_known = 1'b1;
        end else if (en) begin
            best = 0;
            for (int k = 1; k < 16; k++)
                if (int'(stim[k]) > int'(stim[best])) best = k;
            if (int'(stim[best]) > m_max) begin
                m_max = int'(stim[best]);
                m_arg = (m_cnt * 16 + best) % 256;
            end
            m_cnt   = m_cnt + 1;
            m_valid = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit en);
        @(negedge clk);
        rst    = r;
        enable = en;
        for (int k = 0; k < 16; k++) in_v[k] = stim[k];
        @(posedge clk);
        model_update(r, en);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < 16; k++) stim[k] = 8'(v);
    endtask

    task automatic expect_lit(input string name, input int emax, input int earg);
        #1;
        n_tests++;
        if (int'(max_o) != emax || int'(argmax_o) != earg) begin
            n_fail++;
            $display("FAIL %s: got max=%0d argmax=%0d, want max=%0d argmax=%0d",
                     name, max_o, argmax_o, emax, earg);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            n_tests++;
            if (int'(max_o) != m_max || int'(argmax_o) != m_arg) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got max=%0d argmax=%0d, want max=%0d argmax=%0d",
                         $time, max_o, argmax_o, m_max, m_arg);
            end
`ifdef SPA_VALID_OUT_EN
            n_tests++;
            if (valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL valid_cmp t=%0t: got %b want %b", $time, valid_o, m_valid);
            end
`endif
        end
    end

    initial begin
        fill(0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        expect_lit("reset", -128, 0);

        // Ramp: vector c has in[i] = c + i
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 16; k++) stim[k] = 8'(c + k);
            step(1'b0, 1'b1);
            if (c == 0)  expect_lit("ramp_v0", 15, 15);
            if (c == 7)  expect_lit("ramp_v7", 22, 127);
            if (c == 15) expect_lit("ramp_v15", 30, 255);
        end
        for (int k = 0; k < 16; k++) stim[k] = 8'(16 + k);
        step(1'b0, 1'b1);
        expect_lit("wrap", 31, 15);

        // Ties
        step(1'b1, 1'b0);
        fill(5);
        step(1'b0, 1'b1);
        expect_lit("tie_v0", 5, 0);
        step(1'b0, 1'b1);
        expect_lit("tie_v1", 5, 0);
        fill(0); stim[9] = 8'sd6;
        step(1'b0, 1'b1);
        expect_lit("tie_v2", 6, 41);

        // Negatives
        step(1'b1, 1'b0);
        for (int k = 0; k < 16; k++) stim[k] = 8'(-100 + k);
        stim[3] = -8'sd1;
        step(1'b0, 1'b1);
        expect_lit("neg", -1, 3);
        step(1'b1, 1'b0);
        fill(-128);
        step(1'b0, 1'b1);
        expect_lit("all_min", -128, 0);

        // Enable gating: large inputs ignored while disabled
        fill(127);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            expect_lit("gated", -128, 0);
        end
        fill(0); stim[2] = 8'sd127;
        step(1'b0, 1'b1);
        expect_lit("gated_next", 127, 18);

        // Reset mid-stream
        step(1'b1, 1'b0);
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 16; k++) stim[k] = 8'($urandom_range(0, 255));
            step(1'b0, 1'b1);
        end
        step(1'b1, 1'b1);
        expect_lit("mid_reset", -128, 0);
        fill(-50); stim[7] = 8'sd10;
        step(1'b0, 1'b1);
        expect_lit("after_reset", 10, 7);

        // Random traffic; small-range values half the time to provoke ties
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 16; k++)
                stim[k] = narrow ? 8'($urandom_range(0, 7) - 4) : 8'($urandom_range(0, 255));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
